// File: rtl/mc_core.sv
// Multicycle MIPS-subset core: one shared memory port, and one FSM state per
// micro-step of each instruction. Supports lw/sw/beq/bne/addi/j plus R-type add/sub/and/or/slt.
module mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BNE_EN   = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        memreq,
  output logic        memwe,
  output logic [31:0] memaddr,
  output logic [31:0] memwdata,
  input  logic [31:0] memrdata,
  input  logic        memready,
  output logic [31:0] pc,
  output logic [3:0]  state,
  output logic        retired,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] mdr_reg, mdr_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [31:0] aluout_reg, aluout_next;
  logic        illegal_reg;
  logic [31:0] rf_reg [0:31];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] signimm;

  assign opcode  = ir_reg[31:26];
  assign rs      = ir_reg[25:21];
  assign rt      = ir_reg[20:16];
  assign rd      = ir_reg[15:11];
  assign funct   = ir_reg[5:0];
  assign signimm = {{16{ir_reg[15]}}, ir_reg[15:0]};

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    mdr_next    = mdr_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    aluout_next = aluout_reg;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    memreq      = 1'b0;
    memwe       = 1'b0;
    memaddr     = pc_reg;
    retired     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        memreq = 1'b1;
        if (memready) begin
          ir_next    = memrdata;
          pc_next    = pc_reg + 32'd4;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        a_next      = rf_reg[rs];
        b_next      = rf_reg[rt];
        aluout_next = pc_reg + (signimm << 2);
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_BNE:       state_next = (BNE_EN != 0) ? S_BRANCH : S_ERROR;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        aluout_next = a_reg + signimm;
        state_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memreq  = 1'b1;
        memaddr = aluout_reg;
        if (memready) begin
          mdr_next   = memrdata;
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_waddr   = rt;
        rf_wdata   = mdr_reg;
        retired    = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        memreq  = 1'b1;
        memwe   = 1'b1;
        memaddr = aluout_reg;
        if (memready) begin
          retired    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        state_next = S_ALUWB;
        case (funct)
          6'b100000: aluout_next = a_reg + b_reg;
          6'b100010: aluout_next = a_reg - b_reg;
          6'b100100: aluout_next = a_reg & b_reg;
          6'b100101: aluout_next = a_reg | b_reg;
          6'b101010: aluout_next = {31'd0, $signed(a_reg) < $signed(b_reg)};
          default:   state_next  = S_ERROR;
        endcase
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        rf_waddr   = rd;
        rf_wdata   = aluout_reg;
        retired    = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut already holds the branch target computed during DECODE
        if (((opcode == OP_BEQ) && (a_reg == b_reg)) ||
            ((opcode == OP_BNE) && (a_reg != b_reg)))
          pc_next = aluout_reg;
        retired    = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        aluout_next = a_reg + signimm;
        state_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we      = 1'b1;
        rf_waddr   = rt;
        rf_wdata   = aluout_reg;
        retired    = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_next    = {pc_reg[31:28], ir_reg[25:0], 2'b00};
        retired    = 1'b1;
        state_next = S_FETCH;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'd0;
      mdr_reg     <= 32'd0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      aluout_reg  <= 32'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      mdr_reg     <= mdr_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      aluout_reg  <= aluout_next;
      illegal_reg <= (state_next == S_ERROR);
    end
  end

  // Entry 0 has no write path, so it stays at its reset value of zero
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (reset)
          rf_reg[gi] <= 32'd0;
        else if (rf_we && (gi != 0) && (rf_waddr == 5'(gi)))
          rf_reg[gi] <= rf_wdata;
      end
    end
  endgenerate

  assign memwdata = b_reg;
  assign pc       = pc_reg;
  assign state    = state_reg;
  assign illegal  = illegal_reg;
  assign dbg_data = rf_reg[dbg_addr];

endmodule
